// File: rtl/four_by_four_ram_arb_pkg.sv
// four_by_four_ram_arb_pkg: shared state encoding and RAM op constants for the 4x4 RAM arbiter
package four_by_four_ram_arb_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, VSETUP, VSTROBE, DONE} state_e;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;
  localparam int CNT_W = 4;
endpackage

// File: rtl/four_by_four_ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; one-hot grant, pointer remembers the last served port
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_q, last_d;
  always_comb begin
    gnt = &req ? (last_q ? 2'b01 : 2'b10) : req;
    last_d = en && |req ? gnt[1] : last_q;
  end
  always_ff @(posedge clk) last_q <= rst ? 1'b1 : last_d;
endmodule

// File: rtl/four_by_four_ram_arbiter.sv
// four_by_four_ram_arbiter: two-port setup/strobe/hold access sequencer for the unclocked 4x4 RAM.
// Define RAM_ARB_WR_VERIFY_EN to read back every write and flag mismatches on verify_err.
module four_by_four_ram_arbiter
  import four_by_four_ram_arb_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              rd_wr0,
  input  logic              rd_wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rsp_data,
  output logic              verify_err,
  output logic              mem_en,
  output logic              rd_wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);
  state_e state_q, state_d;
  logic win_q, win_d, op_q, op_d, mem_en_q, mem_en_d, rd_wr_q, rd_wr_d, fin;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, rsp_q, rsp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] arb_gnt, gnt_q, gnt_d, done_q, done_d;
`ifdef RAM_ARB_WR_VERIFY_EN
  logic verr_q, verr_d;
`endif
  rr_arb2 u_arb (.clk(clk), .rst(rst), .req({req1, req0}), .en(state_q == IDLE), .gnt(arb_gnt));
  assign fin = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    op_d = op_q;
    addr_d = addr_q;
    wr_data_d = wr_data_q;
    cnt_d = fin ? cnt_q : cnt_q - CNT_W'(1);
    mem_en_d = 1'b0;
    rd_wr_d = rd_wr_q;
    rsp_d = rsp_q;
    gnt_d = 2'b00;
`ifdef RAM_ARB_WR_VERIFY_EN
    verr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        rd_wr_d = RD;
        if (|arb_gnt) begin
          state_d = SETUP;
          win_d = arb_gnt[1];
          gnt_d = arb_gnt;
          op_d = arb_gnt[1] ? rd_wr1 : rd_wr0;
          addr_d = arb_gnt[1] ? addr1 : addr0;
          wr_data_d = arb_gnt[1] ? wr_data1 : wr_data0;
          rd_wr_d = op_d;
        end
      end
      SETUP: begin
        state_d = STROBE;
        mem_en_d = 1'b1;
        cnt_d = CNT_LOAD;
      end
      STROBE: begin
        mem_en_d = !fin;
        if (fin) begin
          rsp_d = op_q == RD ? rd_data : rsp_q;
`ifdef RAM_ARB_WR_VERIFY_EN
          state_d = op_q == RD ? DONE : VSETUP;
          rd_wr_d = RD;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef RAM_ARB_WR_VERIFY_EN
      VSETUP: begin
        state_d = VSTROBE;
        mem_en_d = 1'b1;
        cnt_d = CNT_LOAD;
      end
      VSTROBE: begin
        mem_en_d = !fin;
        if (fin) begin
          rsp_d = rd_data;
          verr_d = rd_data != wr_data_q;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        rd_wr_d = RD;
      end
      default: state_d = IDLE;
    endcase
    done_d = state_d == DONE ? {win_q, !win_q} : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q <= 1'b0;
      op_q <= RD;
      mem_en_q <= 1'b0;
      rd_wr_q <= RD;
      addr_q <= '0;
      wr_data_q <= '0;
      rsp_q <= '0;
      cnt_q <= '0;
      gnt_q <= 2'b00;
      done_q <= 2'b00;
`ifdef RAM_ARB_WR_VERIFY_EN
      verr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      op_q <= op_d;
      mem_en_q <= mem_en_d;
      rd_wr_q <= rd_wr_d;
      addr_q <= addr_d;
      wr_data_q <= wr_data_d;
      rsp_q <= rsp_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
`ifdef RAM_ARB_WR_VERIFY_EN
      verr_q <= verr_d;
`endif
    end
  end
  assign {gnt1, gnt0} = gnt_q;
  assign {done1, done0} = done_q;
  assign rsp_data = rsp_q;
  assign mem_en = mem_en_q;
  assign rd_wr = rd_wr_q;
  assign addr = addr_q;
  assign wr_data = wr_data_q;
`ifdef RAM_ARB_WR_VERIFY_EN
  assign verify_err = verr_q;
`else
  assign verify_err = 1'b0;
`endif
endmodule

// File: tb/tb_four_by_four_ram_arbiter.sv
// tb_four_by_four_ram_arbiter: two arbiters (STROBE_CYCLES 1 and 3), each behind a behavioural 4x4 RAM,
// driven by random two-port traffic and checked against a scoreboard of expected completions.
module tb_four_by_four_ram_arbiter;
  typedef struct {
    bit p;
    bit rd;
    bit chk;
    logic [3:0] data;
    bit verr;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  logic [1:0] rst;
  logic [1:0] req [2], op [2], gnt [2], done [2];
  logic [1:0] ain [2][2];
  logic [3:0] din [2][2];
  logic [3:0] rsp [2], wdo [2], rdd [2];
  logic [1:0] ao [2];
  logic [1:0] verr, mem_en, rdw;
  logic [3:0] ram [2][4];
  logic [3:0] mdl [2][4];
  bit corrupt [2];
  exp_t sb [2][$];
  function automatic int s_of(input int i);
    return i == 0 ? 1 : 3;
  endfunction
  four_by_four_ram_arbiter #(.STROBE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req0(req[0][0]), .req1(req[0][1]), .rd_wr0(op[0][0]), .rd_wr1(op[0][1]),
    .addr0(ain[0][0]), .addr1(ain[0][1]), .wr_data0(din[0][0]), .wr_data1(din[0][1]),
    .gnt0(gnt[0][0]), .gnt1(gnt[0][1]), .done0(done[0][0]), .done1(done[0][1]), .rsp_data(rsp[0]),
    .verify_err(verr[0]), .mem_en(mem_en[0]), .rd_wr(rdw[0]), .addr(ao[0]), .wr_data(wdo[0]), .rd_data(rdd[0]));
  four_by_four_ram_arbiter #(.STROBE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req0(req[1][0]), .req1(req[1][1]), .rd_wr0(op[1][0]), .rd_wr1(op[1][1]),
    .addr0(ain[1][0]), .addr1(ain[1][1]), .wr_data0(din[1][0]), .wr_data1(din[1][1]),
    .gnt0(gnt[1][0]), .gnt1(gnt[1][1]), .done0(done[1][0]), .done1(done[1][1]), .rsp_data(rsp[1]),
    .verify_err(verr[1]), .mem_en(mem_en[1]), .rd_wr(rdw[1]), .addr(ao[1]), .wr_data(wdo[1]), .rd_data(rdd[1]));
  // Unclocked RAM: writes while enabled in write mode, drives data only while enabled for read.
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (mem_en[i] && !rdw[i]) ram[i][ao[i]] <= wdo[i];
  assign rdd[0] = mem_en[0] && rdw[0] ? ram[0][ao[0]] ^ {3'b000, corrupt[0]} : 4'hx;
  assign rdd[1] = mem_en[1] && rdw[1] ? ram[1][ao[1]] ^ {3'b000, corrupt[1]} : 4'hx;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask
  task automatic issue(input int i, input int p, input bit rd, input logic [1:0] a, input logic [3:0] d,
                       output int lat);
    int t0;
    bit got;
    exp_t e;
    t0 = cyc;
    got = 1'b0;
    req[i][p] = 1'b1;
    op[i][p] = rd;
    ain[i][p] = a;
    din[i][p] = d;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = gnt[i][p];
    end
    req[i][p] = 1'b0;
    lat = cyc - t0;
    check($sformatf("gnt_arrives i%0d p%0d", i, p), 32'(got), 1);
    if (!got) return;
    e.p = p[0];
    e.rd = rd;
    e.verr = 1'b0;
    e.cyc = cyc + 1 + s_of(i);
    e.chk = rd;
    e.data = mdl[i][a];
    if (!rd) begin
      mdl[i][a] = d;
`ifdef RAM_ARB_WR_VERIFY_EN
      e.chk = 1'b1;
      e.cyc += 1 + s_of(i);
      e.data = d ^ {3'b000, corrupt[i]};
      e.verr = corrupt[i];
`endif
    end
    sb[i].push_back(e);
  endtask
  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (sb[i].size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain i%0d", i), sb[i].size(), 0);
    @(negedge clk);
  endtask
  // Monitor: arbitration fairness, strobe shape and completions, using values the DUT saw at the edge.
  logic [1:0] rst_s = 2'b11;
  logic [1:0] rq_s [2];
  always @(posedge clk) begin
    rst_s <= rst;
    rq_s <= req;
  end
  bit last [2], pm [2], pr [2];
  int run [2];
  always @(negedge clk) begin : mon
    exp_t e;
    bit w, ew;
    for (int i = 0; i < 2; i++) begin
      if (rst_s[i]) begin
        last[i] = 1'b1;
        pm[i] = 1'b0;
        pr[i] = 1'b1;
        run[i] = 0;
      end else begin
        check("single_gnt", 32'($countones(gnt[i]) <= 1), 1);
        check("single_done", 32'($countones(done[i]) <= 1), 1);
        if (|gnt[i]) begin
          w = gnt[i][1];
          ew = &rq_s[i] ? !last[i] : rq_s[i][1];
          check("rr_winner", 32'(w), 32'(ew));
          last[i] = w;
        end
        if (|done[i]) begin
          if (sb[i].size() == 0) check("done_unexpected", 32'(done[i]), 0);
          else begin
            e = sb[i].pop_front();
            check("done_port", 32'(done[i]), e.p ? 2 : 1);
            check("done_cycle", cyc, e.cyc);
            check("verify_err_done", 32'(verr[i]), 32'(e.verr));
            if (e.chk) check("rsp_data", 32'(rsp[i]), 32'(e.data));
          end
        end else check("verify_err_quiet", 32'(verr[i]), 0);
        if (pm[i] && !mem_en[i]) begin
          check("strobe_len", run[i], s_of(i));
          run[i] = 0;
        end
        if (mem_en[i]) run[i]++;
`ifndef RAM_ARB_WR_VERIFY_EN
        if (mem_en[i] != pm[i]) check("rd_wr_stable_at_en_edge", 32'(rdw[i]), 32'(pr[i]));
        if (rdw[i] != pr[i]) check("rd_wr_change_en_low", 32'({pm[i], mem_en[i]}), 0);
`endif
        pm[i] = mem_en[i];
        pr[i] = rdw[i];
      end
    end
  end
  task automatic run_inst(input int i);
    int lat;
    for (int a = 0; a < 4; a++) issue(i, a & 1, 1'b0, 2'(a), 4'($urandom_range(0, 15)), lat);
    wait_idle(i);
    if (i == 0) begin
      issue(0, 0, 1'b0, 2'd2, 4'hA, lat);
      check("gnt_latency_wr", lat, 1);
      wait_idle(0);
      issue(0, 0, 1'b1, 2'd2, 4'h0, lat);
      check("gnt_latency_rd", lat, 1);
      wait_idle(0);
      check("readback_A", 32'(rsp[0]), 32'hA);
    end else begin
      issue(1, 0, 1'b0, 2'd1, 4'h5, lat);
      check("gnt_latency_s3", lat, 1);
      wait_idle(1);
      issue(1, 1, 1'b1, 2'd1, 4'h0, lat);
      wait_idle(1);
      check("readback_5", 32'(rsp[1]), 32'h5);
      issue(1, 0, 1'b1, 2'd3, 4'h0, lat);
      @(negedge clk);
      check("rst_pre_mem_en", 32'(mem_en[1]), 1);
      rst[1] = 1'b1;
      sb[1].delete();
      @(negedge clk);
      check("rst_mem_en", 32'(mem_en[1]), 0);
      check("rst_rd_wr", 32'(rdw[1]), 1);
      check("rst_done", 32'(done[1]), 0);
      rst[1] = 1'b0;
      repeat (8) @(negedge clk);
      issue(1, 1, 1'b1, 2'd1, 4'h0, lat);
      check("post_rst_gnt_latency", lat, 1);
      wait_idle(1);
    end
    fork
      repeat (4) issue(i, 0, 1'b1, 2'd0, 4'h0, lat);
      repeat (4) issue(i, 1, 1'b1, 2'd3, 4'h0, lat);
    join
    wait_idle(i);
`ifdef RAM_ARB_WR_VERIFY_EN
    corrupt[i] = 1'b1;
    issue(i, 1, 1'b0, 2'd2, 4'h6, lat);
    wait_idle(i);
    corrupt[i] = 1'b0;
`endif
    fork
      repeat (30) begin
        issue(i, 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), lat);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (30) begin
        issue(i, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), lat);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    join
    wait_idle(i);
  endtask
  initial begin
    rst = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req[i] = 2'b00;
      op[i] = 2'b11;
      corrupt[i] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        ain[i][p] = 2'd0;
        din[i][p] = 4'd0;
      end
    end
    repeat (3) @(negedge clk);
    rst = 2'b00;
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("idle_mem_en", 32'(mem_en[i]), 0);
        check("idle_rd_wr", 32'(rdw[i]), 1);
        check("idle_gnt", 32'(gnt[i]), 0);
        check("idle_done", 32'(done[i]), 0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      check("reset_addr", 32'(ao[i]), 0);
      check("reset_wr_data", 32'(wdo[i]), 0);
      check("reset_rsp_data", 32'(rsp[i]), 0);
      check("reset_verify_err", 32'(verr[i]), 0);
    end
    fork
      run_inst(0);
      run_inst(1);
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
